// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the 7-segment scan driver: default geometry and
// nibble-select helper also used by ledDecoder users.
package seg_scan_driver_pkg;

    localparam int unsigned DIGITS_DEF = 4;
    localparam int unsigned DIV_W_DEF  = 16;

    // Width of a pointer that counts 0..n-1 (at least one bit).
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Select nibble k of a packed hex word (values up to 16 digits).
    function automatic logic [3:0] nib_sel(input logic [63:0] v, input int unsigned k);
        return v[4*k +: 4];
    endfunction

endpackage

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with optional leading-zero
// blanking. All outputs are registered; index and dig_sel update together.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int unsigned DIGITS = DIGITS_DEF,
    parameter int unsigned DIV_W  = DIV_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic                  blank_lz,
    output logic [3:0]            index,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  scan_tick
);

    localparam int unsigned VW = 4 * DIGITS;
    localparam int unsigned PW = ptr_width(DIGITS);
    localparam logic [PW-1:0] PtrLast = PW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] DigOff = '1;

    logic [VW-1:0]     shadow_q, shadow_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [3:0]        index_q, index_d;
    logic [DIGITS-1:0] dig_sel_q, dig_sel_d;
    logic              scan_tick_q, scan_tick_d;

    logic              tick;
    logic [PW-1:0]     nptr;
    logic [DIGITS-1:0] blank;

    // Digit k>0 is blanked when it and every more-significant nibble are zero.
    function automatic logic [DIGITS-1:0] lz_mask(input logic [VW-1:0] v);
        logic [DIGITS-1:0] m;
        logic              zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above & (v[4*k +: 4] == 4'h0);
            m[k]       = zero_above;
        end
        return m;
    endfunction

    always_comb begin
        tick  = en && (div_q == '1);
        nptr  = (ptr_q == PtrLast) ? '0 : ptr_q + PW'(1);
        blank = blank_lz ? lz_mask(shadow_q) : '0;

        shadow_d    = load ? value_in : shadow_q;
        div_d       = en ? div_q + DIV_W'(1) : div_q;
        ptr_d       = ptr_q;
        index_d     = index_q;
        dig_sel_d   = dig_sel_q;
        scan_tick_d = 1'b0;

        if (tick) begin
            // Outputs come from the pre-edge shadow, so a coincident load waits a slot.
            ptr_d       = nptr;
            index_d     = nib_sel(64'(shadow_q), 32'(nptr));
            scan_tick_d = 1'b1;
            for (int k = 0; k < DIGITS; k++) begin
                dig_sel_d[k] = !((PW'(k) == nptr) && !blank[k]);
            end
        end else if (!en) begin
            dig_sel_d = DigOff;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q    <= '0;
            div_q       <= '0;
            ptr_q       <= '0;
            index_q     <= '0;
            dig_sel_q   <= DigOff;
            scan_tick_q <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            div_q       <= div_d;
            ptr_q       <= ptr_d;
            index_q     <= index_d;
            dig_sel_q   <= dig_sel_d;
            scan_tick_q <= scan_tick_d;
        end
    end

    assign index     = index_q;
    assign dig_sel   = dig_sel_q;
    assign scan_tick = scan_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench: a 4-digit and a 3-digit scanner (tick every 8 clocks)
// run side by side against a slot-level reference model.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] val = '0;

    logic [3:0]  idx4, idx3;
    logic [3:0]  sel4;
    logic [2:0]  sel3;
    logic        tk4, tk3;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model state per instance: 0 -> 4 digits, 1 -> 3 digits.
    int          m_phase [2];
    int          m_ptr   [2];
    logic [15:0] m_shadow[2];
    logic [3:0]  m_index [2];
    logic [3:0]  m_dig   [2];
    logic        m_tick  [2];

    logic [3:0] exp_idx[5] = '{4'h2, 4'hA, 4'h1, 4'hF, 4'h2};
    logic [3:0] exp_sel[5] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};

    always #5 clk = ~clk;

    seg_scan_driver #(.DIGITS(4), .DIV_W(3)) u4 (
        .clk(clk), .rst(rst), .en(en), .load(load), .value_in(val),
        .blank_lz(blank_lz), .index(idx4), .dig_sel(sel4), .scan_tick(tk4)
    );

    seg_scan_driver #(.DIGITS(3), .DIV_W(3)) u3 (
        .clk(clk), .rst(rst), .en(en), .load(load), .value_in(val[11:0]),
        .blank_lz(blank_lz), .index(idx3), .dig_sel(sel3), .scan_tick(tk3)
    );

    function automatic logic [3:0] nib(input logic [15:0] v, input int d);
        return 4'((v >> (4 * d)) & 16'hF);
    endfunction

    function automatic bit lit(input logic [15:0] v, input int d, input logic bl);
        if (!bl || d == 0) return 1'b1;
        return (v >> (4 * d)) != 16'h0;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i]  = 0;
            m_ptr[i]    = 0;
            m_shadow[i] = '0;
            m_index[i]  = '0;
            m_dig[i]    = 4'hF;
            m_tick[i]   = 1'b0;
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int  nd;
            int  d;
            bit  t;
            nd = (i == 0) ? 4 : 3;
            t  = en && (m_phase[i] == 7);
            m_tick[i] = t;
            if (t) begin
                d          = (m_ptr[i] + 1) % nd;
                m_ptr[i]   = d;
                m_index[i] = nib(m_shadow[i], d);
                m_dig[i]   = lit(m_shadow[i], d, blank_lz) ? ~(4'b0001 << d) : 4'hF;
            end else if (!en) begin
                m_dig[i] = 4'hF;
            end
            if (en) m_phase[i] = (m_phase[i] + 1) % 8;
            if (load) m_shadow[i] = (i == 0) ? val : {4'h0, val[11:0]};
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("idx4", 16'(idx4), 16'(m_index[0]));
        chk("sel4", 16'(sel4), 16'(m_dig[0]));
        chk("tick4", 16'(tk4), 16'(m_tick[0]));
        chk("idx3", 16'(idx3), 16'(m_index[1]));
        chk("sel3", 16'(sel3), 16'(m_dig[1][2:0]));
        chk("tick3", 16'(tk3), 16'(m_tick[1]));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load_val(input logic [15:0] v);
        val  = v;
        load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    // Asynchronous reset away from any clock edge, then release on a falling edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        chk({tag, "_sel4"}, 16'(sel4), 16'hF);
        chk({tag, "_idx4"}, 16'(idx4), 16'h0);
        chk({tag, "_tick4"}, 16'(tk4), 16'h0);
        chk({tag, "_sel3"}, 16'(sel3), 16'h7);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Run until the next edge of the 4-digit instance is a tick edge.
    task automatic run_to_tick_edge();
        for (int i = 0; i < 8 && !(en && m_phase[0] == 7); i++) cycle();
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_sel4", 16'(sel4), 16'hF);
        chk("rst_idx4", 16'(idx4), 16'h0);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;

        // First tick after 8 enabled clocks lands on digit 1.
        cycles(7);
        chk("pre_first_tick", 16'(tk4), 16'h0);
        cycle();
        chk("first_tick_sel", 16'(sel4), 16'b1101);
        chk("first_tick_pulse", 16'(tk4), 16'h1);

        // Mid-scan reset blanks at once.
        cycles(5);
        async_reset("midscan");

        // Scan order for 1A2F.
        en = 1'b1;
        blank_lz = 1'b0;
        load_val(16'h1A2F);
        cycles(6);
        for (int s = 0; s < 5; s++) begin
            cycle();
            chk("order_idx", 16'(idx4), 16'(exp_idx[s]));
            chk("order_sel", 16'(sel4), 16'(exp_sel[s]));
            if (s < 4) cycles(7);
        end

        // Leading-zero blanking.
        blank_lz = 1'b1;
        load_val(16'h0030);
        cycles(40);
        load_val(16'h0000);
        cycles(40);

        // Load coinciding with a tick shows the old value for that slot.
        blank_lz = 1'b0;
        load_val(16'h1234);
        cycles(9);
        run_to_tick_edge();
        val  = 16'hBEEF;
        load = 1'b1;
        cycle();
        load = 1'b0;
        chk("collide_tick", 16'(tk4), 16'h1);
        cycles(24);

        // Enable gating: dark one clock after en drops, frozen scan.
        cycles(3);
        en = 1'b0;
        cycle();
        chk("en_off_sel", 16'(sel4), 16'hF);
        cycles(19);
        en = 1'b1;
        cycles(20);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            blank_lz = 1'($urandom_range(0, 1));
            load     = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0: val = 16'($urandom_range(0, 15));
                1: val = 16'($urandom_range(0, 255));
                2: val = 16'h0000;
                default: val = 16'($urandom);
            endcase
            cycle();
        end
        load = 1'b0;
        async_reset("final");
        cycles(10);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
